// File: rtl/sized_data_memory_if.sv
// Request/response bundle between the MEM-stage datapath and the sized data memory.
interface sized_data_memory_if;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [1:0]  Size;
   logic        Unsigned;
   logic [31:0] ReadData;
   logic        ReadValid;
   logic        Ready;
   logic        AccessFault;
   logic [31:0] FaultAddr;

   modport master (
      output Address, WriteData, MemWrite, MemRead, Size, Unsigned,
      input  ReadData, ReadValid, Ready, AccessFault, FaultAddr
   );

   modport slave (
      input  Address, WriteData, MemWrite, MemRead, Size, Unsigned,
      output ReadData, ReadValid, Ready, AccessFault, FaultAddr
   );
endinterface

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with byte/half/word access, 1-cycle registered loads,
// alignment/range faults and an optional zero-fill sequence after reset.
module sized_data_memory #(
   parameter int unsigned ADDR_BITS      = 6,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   sized_data_memory_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;
   localparam int unsigned HI    = ADDR_BITS + 2;
   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
   logic                   clr_we_c;

   logic [31:0]            mem [DEPTH];
   logic [31:0]            raw_q;

   logic                   ready_q, ready_d;
   logic                   valid_q, valid_d;
   logic                   fault_q, fault_d;
   logic [31:0]            fault_addr_q, fault_addr_d;
   logic [1:0]             off_q, off_d;
   logic [1:0]             size_q, size_d;
   logic                   uns_q, uns_d;

   logic                   accept_c, fault_c, do_read_c, do_write_c;
   logic [ADDR_BITS-1:0]   idx_c;
   logic [3:0]             be_c;
   logic [31:0]            wlane_c;
   logic [31:0]            shifted_c, rdata_c;

   // Clear sequencer state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR_ON_RESET ? S_INIT : S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear sequencer next state: one zeroed word per cycle, then run forever
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_we_c = 1'b0;
      case (state_q)
         S_INIT: begin
            clr_we_c = ~rst;
            cnt_d    = cnt_q + ADDR_BITS'(1);
            if (cnt_q == LAST_IDX) state_d = S_RUN;
         end
         default: ;
      endcase
      ready_d = (state_d == S_RUN);
   end

   // Request decode; Ready is a flop so acceptance never loops back to the requester
   always_comb begin
      idx_c      = bus.Address[HI-1:2];
      accept_c   = ready_q & (bus.MemRead | bus.MemWrite);
      fault_c    = (bus.Size == 2'b11)
                 | ((bus.Size == 2'b01) & bus.Address[0])
                 | ((bus.Size == 2'b10) & (bus.Address[1:0] != 2'b00))
                 | ((bus.Address >> HI) != 32'd0);
      do_read_c  = accept_c & bus.MemRead & ~fault_c;
      do_write_c = accept_c & bus.MemWrite & ~fault_c & ~rst;
   end

   // Lane replication plus per-byte enables
   always_comb begin
      be_c    = 4'b0000;
      wlane_c = bus.WriteData;
      case (bus.Size)
         2'b00: begin
            be_c[bus.Address[1:0]] = 1'b1;
            wlane_c = {4{bus.WriteData[7:0]}};
         end
         2'b01: begin
            be_c    = bus.Address[1] ? 4'b1100 : 4'b0011;
            wlane_c = {2{bus.WriteData[15:0]}};
         end
         default: be_c = 4'b1111;
      endcase
   end

   // Storage: nonblocking read of the old word gives read-before-write
   always_ff @(posedge clk) begin
      if (clr_we_c) begin
         mem[cnt_q] <= '0;
      end else if (do_write_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
         end
      end
      if (do_read_c) raw_q <= mem[idx_c];
   end

   always_comb begin
      valid_d      = do_read_c;
      fault_d      = accept_c & fault_c;
      fault_addr_d = fault_d ? bus.Address : fault_addr_q;
      off_d        = do_read_c ? bus.Address[1:0] : off_q;
      size_d       = do_read_c ? bus.Size : size_q;
      uns_d        = do_read_c ? bus.Unsigned : uns_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q      <= ~CLEAR_ON_RESET;
         valid_q      <= 1'b0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
      end else begin
         ready_q      <= ready_d;
         valid_q      <= valid_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
      end
   end

   // Load extraction and extension in the cycle after the array read
   always_comb begin
      shifted_c = raw_q >> {off_q, 3'b000};
      case (size_q)
         2'b00:   rdata_c = uns_q ? {24'd0, shifted_c[7:0]}
                                  : {{24{shifted_c[7]}}, shifted_c[7:0]};
         2'b01:   rdata_c = uns_q ? {16'd0, shifted_c[15:0]}
                                  : {{16{shifted_c[15]}}, shifted_c[15:0]};
         default: rdata_c = raw_q;
      endcase
   end

   assign bus.ReadData    = valid_q ? rdata_c : 32'd0;
   assign bus.ReadValid   = valid_q;
   assign bus.Ready       = ready_q;
   assign bus.AccessFault = fault_q;
   assign bus.FaultAddr   = fault_addr_q;

endmodule

// File: doc/sized_data_memory.md
# sized_data_memory

Parametrised byte-addressed data memory for the MIPS datapath's MEM stage. It replaces the fixed 64-word, word-only RAM wrapper. It adds byte, halfword and word loads and stores with sign or zero extension, and registers the read with 1-cycle latency. It faults on misaligned or out-of-range accesses, and a hardware clear sequence zeroes the memory after reset.

## Interface
Parameters:
- ADDR_BITS, 6, word-address width; depth = 2^ADDR_BITS 32-bit words
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = Ready immediately, contents undefined

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- Address  in  32  byte address
- WriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- MemWrite  in  1  store request
- MemRead  in  1  load request
- Size  in  2  00 byte, 01 half, 10 word, 11 illegal
- Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- ReadData  out  32  load result, extended; 0 whenever ReadValid=0
- ReadValid  out  1  ReadData valid this cycle
- Ready  out  1  requests accepted this cycle
- AccessFault  out  1  one-cycle pulse reporting a rejected request
- FaultAddr  out  32  Address of the most recent faulted request

## Operation
- FSM states: INIT, RUN. Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN. Clear counter resets to 0.
- In INIT, one word is written to zero per cycle at address = counter. Ready=0, and MemRead/MemWrite are ignored with no fault. After word 2^ADDR_BITS-1 is written, the FSM enters RUN. The state never leaves RUN except by reset.
- Accept condition: Ready & (MemRead | MemWrite).
- A request is faulted if any of the following hold:
  - Size=11
  - half with Address[0]=1
  - word with Address[1:0]≠00
  - Address[31:ADDR_BITS+2] ≠ 0
- A faulted request performs no write and no read. The next cycle gives AccessFault=1, ReadValid=0 and FaultAddr=Address.
- Store lane mapping, word index Address[ADDR_BITS+1:2]:
  - byte: WriteData[7:0] goes to lane Address[1:0]
  - half: WriteData[15:0] goes to lanes {Address[1],0}+1 : {Address[1],0}
  - word: all four lanes
  - Unselected lanes keep their value (per-byte write enables).
- Load: the raw word is read and Address[1:0], Size and Unsigned are registered. In the next cycle the selected byte or half is extracted and extended to 32 bits.
- Simultaneous MemRead & MemWrite, same address: the write is performed and the read returns the pre-write word (read-before-write).
- Back-to-back operations are fully pipelined. A store in cycle N followed by a load of the same address in cycle N+1 returns the new data.
- Reset outputs: ReadData=0, ReadValid=0, AccessFault=0, FaultAddr=0. Ready=0 if CLEAR_ON_RESET=1, else 1.
- Reset during INIT restarts the counter at 0. Reset in RUN discards any in-flight load: ReadValid=0 in the cycle after reset.

## Timing
- Clear sequence: Ready=0 for exactly 2^ADDR_BITS cycles after rst deasserts. Ready=1 on the following edge.
- Load latency: 1 cycle. A request at edge N gives ReadValid/ReadData after edge N+1, both held for one cycle.
- Store: memory updates at the accepting edge.
- AccessFault: asserted for the one cycle after the faulting edge. FaultAddr updates at that same edge and holds until the next fault or reset.
- Throughput: one request per cycle in RUN. Ready has no dependency on the request inputs.

## Test plan
- Reset with ADDR_BITS=6, CLEAR_ON_RESET=1, MemRead held high during INIT -> Ready=0 for 64 cycles with no ReadValid and no fault. After the clear, a load word at 0xFC returns 0x00000000.
- Store word 0x80F1_7F22 at 0x10, then load byte signed at 0x11, byte unsigned at 0x13, half signed at 0x12 -> 0x0000007F, 0x00000080, 0xFFFF80F1, each one cycle after its request.
- Store byte 0xAB at 0x21 over word 0x11223344 at 0x20 -> load word at 0x20 returns 0x1122AB44. Store half 0xBEEF at 0x22 -> 0xBEEFAB44.
- Load word at 0x06, half at 0x05, Size=11 at 0x00, and word at 0x100 (ADDR_BITS=6) -> each gives AccessFault=1, ReadValid=0, FaultAddr equal to that address, and memory unchanged.
- Same-cycle store 0xDEADBEEF and load at 0x30 (old value 0x0) -> ReadData=0x00000000. A load at 0x30 the next cycle -> 0xDEADBEEF.
- rst asserted at clear cycle 20 -> Ready stays 0 for a full 64 cycles after rst deasserts. rst asserted with a load in flight -> no ReadValid.
